// File: rtl/line_buffer_arbiter.sv
// Shares one single-port 1024x16 line-buffer RAM between a posted PPU pixel writer
// and a scan-doubler reader, with ping-pong banks, starvation-bounded arbitration and a clear sequencer.
module line_buffer_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [8:0]  wr_x,
    input  logic [14:0] wr_pixel,
    output logic        wr_full,
    input  logic        line_start,
    input  logic        rd_req,
    input  logic [8:0]  rd_x,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [14:0] rd_data,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic        overflow,
    output logic [9:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {ST_RUN, ST_CLEAR} state_t;

    state_t         state;
    logic           run_en;
    logic           wr_bank;
    logic [24:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  head_ptr;
    logic [PW-1:0]  tail_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [SW-1:0]  starve_cnt;
    logic [9:0]     clr_cnt;
    logic           rd_p1;
    logic           rd_p2;
    logic           fifo_empty;
    logic           fifo_full;
    logic           starve;
    logic           rd_grant;
    logic           wr_grant;
    logic           enq;
    logic [24:0]    head;
    logic           rdata_unused;

    assign rdata_unused = mem_rdata[15];

    // Read handshake: a read is accepted on any rising edge where rd_req && rd_ready;
    // rd_valid pulses exactly two edges later with the RAM word for that request.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(FIFO_DEPTH));
        starve     = !fifo_empty && (starve_cnt == SW'(STARVE_MAX));
        rd_ready   = run_en && (state == ST_RUN) && !starve;
        rd_grant   = rd_req && rd_ready;
        wr_grant   = run_en && (state == ST_RUN) && !fifo_empty && (starve || !rd_req);
        enq        = wr_valid && !fifo_full;
        head       = fifo_mem[head_ptr];
        count_nxt  = count + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, wr_grant};
    end

    // Each entry carries the bank that was current when the pixel arrived.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[tail_ptr] <= {wr_bank, wr_x, wr_pixel};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            run_en     <= 1'b0;
            wr_bank    <= 1'b0;
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            starve_cnt <= '0;
            clr_cnt    <= '0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            wr_full    <= 1'b0;
            overflow   <= 1'b0;
            clear_busy <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            run_en   <= 1'b1;
            wr_bank  <= wr_bank ^ line_start;
            count    <= count_nxt;
            wr_full  <= (count_nxt == CW'(FIFO_DEPTH));
            if (enq) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (wr_grant) begin
                head_ptr <= head_ptr + 1'b1;
            end
            // A pixel arriving at a full FIFO is lost even if an entry leaves this edge.
            if (wr_valid && fifo_full) begin
                overflow <= 1'b1;
            end

            if (state != ST_RUN || fifo_empty || wr_grant) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            rd_p1    <= rd_grant;
            rd_p2    <= rd_p1;
            rd_valid <= rd_p2;
            if (rd_p2) begin
                rd_data <= mem_rdata[14:0];
            end

            mem_we <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (wr_grant) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= head[24:15];
                        mem_wdata <= {1'b0, head[14:0]};
                    end else if (rd_grant) begin
                        mem_addr  <= {~wr_bank, rd_x};
                    end
                    if (clear_req) begin
                        state      <= ST_CLEAR;
                        clear_busy <= 1'b1;
                        clr_cnt    <= '0;
                    end
                end
                ST_CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= clr_cnt;
                    mem_wdata <= '0;
                    clr_cnt   <= clr_cnt + 1'b1;
                    if (clr_cnt == 10'd1023) begin
                        state      <= ST_RUN;
                        clear_busy <= 1'b0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/line_buffer_arbiter.md
Name: line_buffer_arbiter

Overview:
- Shares one single-port 1024x16 line-buffer RAM (SPRAM) between two requesters.
- PPU pixel writer: posted writes, buffered in a small FIFO.
- Scan-doubler reader: timing-critical reads with a ready/valid handshake.
- Manages ping-pong banks (write bank / read bank), starvation-bounded arbitration and a whole-buffer clear sequencer. Sits between the PPU pixel stream and the video scan-out logic.

Parameters:
- FIFO_DEPTH, 4: write FIFO entries (power of two, >=2).
- STARVE_MAX, 7: consecutive cycles a pending write may be blocked before it preempts a read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_valid  in  1  pixel write strobe
- wr_x  in  9  pixel x position
- wr_pixel  in  15  BGR555 pixel
- wr_full  out  1  FIFO full (registered)
- line_start  in  1  pulse: toggle write bank
- rd_req  in  1  read request
- rd_x  in  9  read x position
- rd_ready  out  1  read accepted this cycle when rd_req & rd_ready
- rd_valid  out  1  read data valid pulse
- rd_data  out  15  read pixel
- clear_req  in  1  pulse: zero entire RAM
- clear_busy  out  1  clear in progress
- overflow  out  1  sticky: write dropped
- mem_addr  out  10  RAM address (registered)
- mem_wdata  out  16  RAM write data (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_rdata  in  16  RAM read data, valid the cycle after RAM samples the address

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State RUN; wr_bank=0; FIFO empty; starve_cnt=0; clear counter=0.
  - All outputs 0, including rd_ready, mem_we, overflow, clear_busy, wr_full.
  - rd_ready may assert the cycle after rst_n rises.
  - Reset mid-clear or mid-read aborts the operation; no rd_valid is issued for in-flight reads.
- Banks:
  - wr_bank toggles on each line_start, in any state.
  - Each FIFO entry latches wr_bank at enqueue; write address = {entry_bank, wr_x}.
  - Read address = {~wr_bank, rd_x}, using wr_bank as registered at the handshake edge.
  - line_start in the same cycle as wr_valid: that pixel takes the old bank.
- FIFO:
  - wr_valid with FIFO full (occupancy == FIFO_DEPTH at that edge) drops the pixel and sets overflow, even if a dequeue occurs in the same cycle.
  - wr_full = occupancy == FIFO_DEPTH.
- Arbitration (RUN state, one RAM access per cycle):
  - starve = FIFO non-empty && starve_cnt == STARVE_MAX.
  - rd_ready = RUN && !starve (combinational).
  - Priority 1, starve: dequeue and write; rd_ready=0.
  - Priority 2, rd_req: read.
  - Priority 3, FIFO non-empty: write.
  - Otherwise idle, mem_we=0.
  - starve_cnt increments (saturating) each cycle the FIFO is non-empty and no write is granted; it clears on every write grant or when the FIFO is empty.
- Read latency:
  - Handshake at edge E0 → mem_addr/mem_we=0 registered at E0 → RAM samples at E1 → rd_valid=1 and rd_data=mem_rdata[14:0] registered at E2.
  - Fully pipelined: back-to-back reads give back-to-back rd_valid.
- Write: mem_we=1, mem_wdata={1'b0, pixel}, registered on the grant edge.
- Clear:
  - clear_req in RUN → CLEAR next cycle; clear_busy=1.
  - Issues 1024 writes, addr 0..1023, data 0, one per cycle, rd_ready=0 throughout.
  - After addr 1023 the state returns to RUN and clear_busy falls.
  - Total: clear_busy high exactly 1024 cycles.
  - clear_req during CLEAR is ignored.
  - wr_valid during CLEAR still enqueues (overflow rules apply); the FIFO drains after CLEAR. starve_cnt is held at 0 during CLEAR.
  - clear_req in the same cycle as a read handshake: the read completes normally, then CLEAR begins.
- Address wrap: the clear counter is 10-bit and terminates at 1023; x is not range-checked (x >= 512 aliases within the bank).

Test Plan:
- Reset, then write pixel 0x1234 at x=5 (bank 0), pulse line_start, read x=5 → mem_addr=0x005 with we=1, then read mem_addr=0x005; rd_valid exactly 2 cycles after the handshake, rd_data=0x1234.
- Hold rd_req=1 continuously and enqueue one write → rd_ready drops for exactly 1 cycle, 8 cycles after enqueue (STARVE_MAX=7); the write is issued that cycle and starve_cnt returns to 0.
- With rd_req=1 constantly, issue 5 consecutive wr_valid → wr_full=1 after the 4th; the 5th is dropped; overflow=1 and stays set until rst_n=0.
- Pulse clear_req → clear_busy high exactly 1024 cycles, mem_we=1 with data 0 at addresses 0..1023 in order; rd_ready=0 throughout; a write enqueued mid-clear is issued the cycle after clear_busy falls.
- line_start coincident with wr_valid x=3 → entry uses the old bank (addr 0x003); the next wr_valid x=3 uses addr 0x203; the subsequent read x=3 addresses 0x003.
- Assert rst_n=0 mid-clear and with one read in flight → next cycle all outputs 0, no rd_valid, clear_busy=0, FIFO empty.
